program_loader: RTL and testbench
=================================

PROGRAM_LOADER -- requirements
Module: program_loader

Interface
REQ-001 Parameter ADDR_W, default 8, program memory address width.
REQ-002 Parameter DATA_W, default 8, program memory word width.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  asynchronous, active-high; forces the reset state immediately, independent of clk.
REQ-005 start  input  1  level-sampled request to begin a load; honoured only in IDLE, DONE or ERROR.
REQ-006 rx_data  input  DATA_W  incoming byte-stream word.
REQ-007 rx_valid  input  1  rx_data valid.
REQ-008 rx_ready  output  1  loader can accept rx_data this cycle.
REQ-009 pm_wr_addr  output  ADDR_W  program memory write address.
REQ-010 pm_wr_data  output  DATA_W  program memory write data.
REQ-011 pm_wren  output  1  program memory write strobe, one cycle per word.
REQ-012 cpu_reset  output  1  holds the processor in reset; connects to the processor reset input.
REQ-013 busy  output  1  load in progress (LEN, DATA or CHK).
REQ-014 done  output  1  last load completed with a good checksum.
REQ-015 error  output  1  last load failed its checksum.
REQ-016 byte_count  output  ADDR_W  data words written so far in the current load.

Function
REQ-017 FSM states SHALL be IDLE, LEN, DATA, CHK, DONE, ERROR.
REQ-018 Transfer SHALL occur only on a cycle with rx_valid=1 and rx_ready=1; rx_ready=1 in LEN, DATA and CHK only, and it SHALL be combinational from state only, never from rx_valid.
REQ-019 In IDLE, DONE or ERROR, start=1 SHALL move to LEN next cycle; clear done, error, byte_count, the address counter and the running sum; and assert cpu_reset.
REQ-020 In LEN, start SHALL be ignored; the transferred word is load length N, with 0 meaning 2^ADDR_W, and the next state is DATA.
REQ-021 In DATA, each transfer SHALL register pm_wr_data=rx_data and pm_wr_addr=address counter with pm_wren=1 on the following cycle (latency 1); pm_wren=0 on all other cycles.
REQ-022 After each DATA transfer: address counter and byte_count +1, wrapping modulo 2^ADDR_W; running sum += rx_data modulo 2^DATA_W.
REQ-023 When the Nth data word transfers, the next state SHALL be CHK; pm_wr_addr SHALL never exceed N-1 within one load.
REQ-024 In CHK, the transferred word SHALL be compared with the running sum: equal -> DONE, else -> ERROR.
REQ-025 DONE: cpu_reset=0, done=1, busy=0; cpu_reset SHALL deassert on the clock edge that enters DONE.
REQ-026 ERROR: cpu_reset=1, error=1, busy=0; exit only via start or reset.
REQ-027 cpu_reset SHALL be 1 in every state except DONE, so the processor never runs a partial image.
REQ-028 Stalls (rx_valid=0) in LEN, DATA or CHK SHALL hold all state; there is no timeout.
REQ-029 pm_wr_addr and pm_wr_data SHALL hold their last values when pm_wren=0.
REQ-030 All outputs SHALL be registered except rx_ready and busy, which decode state.

Reset
REQ-031 reset=1 SHALL asynchronously force state IDLE, cpu_reset=1, pm_wren=0, rx_ready=0, busy=0, done=0, error=0, byte_count=0, pm_wr_addr=0, pm_wr_data=0, address counter=0, running sum=0.
REQ-032 reset asserted mid-load SHALL abort the load and suppress any pending pm_wren in the same cycle; words already written are not erased.
REQ-033 After reset deasserts, the block SHALL stay in IDLE until start=1.

Verification
REQ-034 start; stream 03,11,22,33,66 -> writes (00,11),(01,22),(02,33), one pm_wren each, done=1, cpu_reset falls on DONE entry, byte_count=3.
REQ-035 start; stream 02,10,20,31 -> two writes, error=1, done=0, cpu_reset stays 1; then start with good image -> done=1.
REQ-036 start; LEN=00, 256 words of value 01, checksum 00 -> addresses 00..FF each written once, done=1, byte_count wraps to 00.
REQ-037 Random rx_valid gaps during a 4-word load -> writes identical to the gap-free case; no pm_wren while rx_valid=0.
REQ-038 reset pulsed asynchronously mid-clock after word 2 of 5 -> immediate IDLE, cpu_reset=1, no further pm_wren; start=1 during DATA has no effect.

Source files
------------

// File: rtl/program_loader.sv
// Streams a length-prefixed, checksummed image into program memory and
// holds the processor in reset until a complete, verified image is loaded.
module program_loader #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [DATA_W-1:0] rx_data,
  input  logic              rx_valid,
  output logic              rx_ready,
  output logic [ADDR_W-1:0] pm_wr_addr,
  output logic [DATA_W-1:0] pm_wr_data,
  output logic              pm_wren,
  output logic              cpu_reset,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [ADDR_W-1:0] byte_count
);

  typedef enum logic [2:0] {
    S_IDLE, S_LEN, S_DATA, S_CHK, S_DONE, S_ERROR
  } state_t;

  localparam logic [ADDR_W-1:0] ONE_A = 1;

  state_t            r_state, w_next;
  logic [ADDR_W-1:0] r_addr, r_last, r_wr_addr;
  logic [DATA_W-1:0] r_sum, r_wr_data;
  logic              r_wren, r_cpu_rst, r_done, r_err;
  logic [ADDR_W-1:0] w_len;
  logic              w_xfer;

  // Length word resized to the address width; a length of 0 yields a last
  // index of all-ones, i.e. a full 2^ADDR_W word image.
  generate
    if (DATA_W >= ADDR_W) begin : g_len_trunc
      assign w_len = rx_data[ADDR_W-1:0];
    end else begin : g_len_ext
      assign w_len = {{(ADDR_W-DATA_W){1'b0}}, rx_data};
    end
  endgenerate

  assign rx_ready = (r_state == S_LEN) || (r_state == S_DATA) || (r_state == S_CHK);
  assign busy     = rx_ready;
  assign w_xfer   = rx_valid && rx_ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE, S_DONE, S_ERROR: if (start) w_next = S_LEN;
      S_LEN:  if (w_xfer) w_next = S_DATA;
      S_DATA: if (w_xfer && (r_addr == r_last)) w_next = S_CHK;
      S_CHK:  if (w_xfer) w_next = (rx_data == r_sum) ? S_DONE : S_ERROR;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_addr    <= '0;
      r_last    <= '0;
      r_sum     <= '0;
      r_wr_addr <= '0;
      r_wr_data <= '0;
      r_wren    <= 1'b0;
      r_cpu_rst <= 1'b1;
      r_done    <= 1'b0;
      r_err     <= 1'b0;
    end else begin
      r_wren    <= 1'b0;
      // Status flags follow the next state so cpu_reset drops on DONE entry.
      r_cpu_rst <= (w_next != S_DONE);
      r_done    <= (w_next == S_DONE);
      r_err     <= (w_next == S_ERROR);
      case (r_state)
        S_IDLE, S_DONE, S_ERROR: begin
          if (start) begin
            r_addr <= '0;
            r_sum  <= '0;
          end
        end
        S_LEN: if (w_xfer) r_last <= w_len - ONE_A;
        S_DATA: begin
          if (w_xfer) begin
            r_wr_addr <= r_addr;
            r_wr_data <= rx_data;
            r_wren    <= 1'b1;
            r_addr    <= r_addr + ONE_A;
            r_sum     <= r_sum + rx_data;
          end
        end
        default: ;
      endcase
    end
  end

  assign pm_wr_addr = r_wr_addr;
  assign pm_wr_data = r_wr_data;
  assign pm_wren    = r_wren;
  assign cpu_reset  = r_cpu_rst;
  assign done       = r_done;
  assign error      = r_err;
  assign byte_count = r_addr;

endmodule

// File: tb/tb_program_loader.sv
// Randomized scoreboard bench for program_loader: expected writes are queued
// as images are streamed, a monitor pops them on every pm_wren.
module tb_program_loader;

  logic       clk = 1'b0;
  logic       reset, start, rx_valid;
  logic [7:0] rx_data;
  logic       rx_ready, pm_wren, cpu_reset, busy, done, error;
  logic [7:0] pm_wr_addr, pm_wr_data, byte_count;

  program_loader #(.ADDR_W(8), .DATA_W(8)) dut (
    .clk(clk), .reset(reset), .start(start), .rx_data(rx_data),
    .rx_valid(rx_valid), .rx_ready(rx_ready), .pm_wr_addr(pm_wr_addr),
    .pm_wr_data(pm_wr_data), .pm_wren(pm_wren), .cpu_reset(cpu_reset),
    .busy(busy), .done(done), .error(error), .byte_count(byte_count)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;
  logic [15:0] exp_q[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  // Monitor: every write strobe must match the oldest outstanding expected write.
  initial begin
    forever begin
      @(negedge clk);
      if (!reset && pm_wren) begin
        if (exp_q.size() == 0) begin
          chk("wren_unexpected", {31'd0, pm_wren}, 32'd0);
        end else begin
          logic [15:0] e;
          e = exp_q.pop_front();
          chk("wr_addr", {24'd0, pm_wr_addr}, {24'd0, e[15:8]});
          chk("wr_data", {24'd0, pm_wr_data}, {24'd0, e[7:0]});
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic send(input logic [7:0] d, input bit gaps);
    if (gaps) begin
      repeat ($urandom_range(0, 3)) begin
        rx_valid = 1'b0;
        rx_data  = 8'($urandom);
        tick();
      end
    end
    rx_valid = 1'b1;
    rx_data  = d;
    chk("rx_ready", {31'd0, rx_ready}, 32'd1);
    tick();
    rx_valid = 1'b0;
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("start_busy", {31'd0, busy}, 32'd1);
    chk("start_cpu_reset", {31'd0, cpu_reset}, 32'd1);
    chk("start_done", {31'd0, done}, 32'd0);
    chk("start_error", {31'd0, error}, 32'd0);
    chk("start_byte_count", {24'd0, byte_count}, 32'd0);
  endtask

  function automatic logic [7:0] sumq(input logic [7:0] d[$]);
    int s = 0;
    foreach (d[i]) s += int'(d[i]);
    return 8'(s % 256);
  endfunction

  // Reference: N words land at addresses 0..N-1; done iff checksum equals sum mod 256.
  task automatic do_load(input logic [7:0] data[$], input logic [7:0] cs, input bit gaps);
    int n;
    bit good;
    n    = data.size();
    good = (sumq(data) == cs);
    do_start();
    send(8'(n % 256), gaps);
    for (int i = 0; i < n; i++) begin
      exp_q.push_back({8'(i % 256), data[i]});
      send(data[i], gaps);
    end
    chk("pre_chk_cpu_reset", {31'd0, cpu_reset}, 32'd1);
    chk("pre_chk_busy", {31'd0, busy}, 32'd1);
    send(cs, gaps);
    chk("end_done", {31'd0, done}, {31'd0, good});
    chk("end_error", {31'd0, error}, {31'd0, !good});
    chk("end_cpu_reset", {31'd0, cpu_reset}, {31'd0, !good});
    chk("end_busy", {31'd0, busy}, 32'd0);
    chk("end_rx_ready", {31'd0, rx_ready}, 32'd0);
    chk("end_byte_count", {24'd0, byte_count}, 32'(n % 256));
    chk("end_writes_pending", 32'(exp_q.size()), 32'd0);
  endtask

  logic [7:0] q[$];

  initial begin
    reset = 1'b1; start = 1'b0; rx_valid = 1'b0; rx_data = 8'h00;
    #2;
    chk("rst_cpu_reset", {31'd0, cpu_reset}, 32'd1);
    chk("rst_pm_wren", {31'd0, pm_wren}, 32'd0);
    chk("rst_rx_ready", {31'd0, rx_ready}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_error", {31'd0, error}, 32'd0);
    chk("rst_byte_count", {24'd0, byte_count}, 32'd0);
    chk("rst_wr_addr", {24'd0, pm_wr_addr}, 32'd0);
    chk("rst_wr_data", {24'd0, pm_wr_data}, 32'd0);
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    rx_valid = 1'b1; rx_data = 8'h5a;
    repeat (3) tick();
    rx_valid = 1'b0;
    chk("idle_hold_busy", {31'd0, busy}, 32'd0);
    chk("idle_hold_rx_ready", {31'd0, rx_ready}, 32'd0);
    chk("idle_hold_cpu_reset", {31'd0, cpu_reset}, 32'd1);

    // Known-good three-word image.
    q.delete(); q.push_back(8'h11); q.push_back(8'h22); q.push_back(8'h33);
    do_load(q, 8'h66, 1'b0);

    // Bad checksum, then recovery with a good image.
    q.delete(); q.push_back(8'h10); q.push_back(8'h20);
    do_load(q, 8'h31, 1'b0);
    q.delete(); for (int i = 0; i < 5; i++) q.push_back(8'($urandom));
    do_load(q, sumq(q), 1'b0);

    // Length 0 means a full 256-word image.
    q.delete(); for (int i = 0; i < 256; i++) q.push_back(8'h01);
    do_load(q, 8'h00, 1'b0);

    // Four-word load with valid gaps.
    q.delete(); for (int i = 0; i < 4; i++) q.push_back(8'($urandom));
    do_load(q, sumq(q), 1'b1);

    for (int k = 0; k < 15; k++) begin
      logic [7:0] cs;
      q.delete();
      for (int i = 0; i < int'($urandom_range(1, 12)); i++) q.push_back(8'($urandom));
      cs = sumq(q);
      if ($urandom_range(0, 3) == 0) cs = cs + 8'($urandom_range(1, 255));
      do_load(q, cs, bit'($urandom_range(0, 1)));
    end

    // Mid-load reset with a write strobe still pending.
    do_start();
    send(8'd5, 1'b0);
    exp_q.push_back({8'd0, 8'hA1});
    send(8'hA1, 1'b0);
    exp_q.push_back({8'd1, 8'hB2});
    start = 1'b1;
    send(8'hB2, 1'b0);
    start = 1'b0;
    chk("start_in_data_busy", {31'd0, busy}, 32'd1);
    chk("start_in_data_count", {24'd0, byte_count}, 32'd2);
    @(negedge clk); #1;
    reset = 1'b1;
    #1;
    chk("midrst_pm_wren", {31'd0, pm_wren}, 32'd0);
    chk("midrst_busy", {31'd0, busy}, 32'd0);
    chk("midrst_cpu_reset", {31'd0, cpu_reset}, 32'd1);
    chk("midrst_byte_count", {24'd0, byte_count}, 32'd0);
    chk("midrst_rx_ready", {31'd0, rx_ready}, 32'd0);
    chk("midrst_pending", 32'(exp_q.size()), 32'd0);
    #1 reset = 1'b0;
    rx_valid = 1'b1; rx_data = 8'hC3;
    repeat (5) tick();
    rx_valid = 1'b0;
    chk("post_rst_busy", {31'd0, busy}, 32'd0);
    chk("post_rst_done", {31'd0, done}, 32'd0);

    q.delete(); for (int i = 0; i < 3; i++) q.push_back(8'($urandom));
    do_load(q, sumq(q), 1'b1);

    repeat (3) tick();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
